// File: rtl/cpu_mem_pkg.sv
// Shared types and sizes for the CPU data-SRAM port and its local responders.
package cpu_mem_pkg;
  localparam int WORD_W      = 32;
  localparam int BYTE_LANES  = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dsram_state_t;
endpackage

// File: rtl/dsram_wait_responder_if.sv
// Core-side data-SRAM port: request fields from the core, read data and stall back.
interface dsram_wait_responder_if;
  import cpu_mem_pkg::*;

  logic                  data_sram_en;
  logic [BYTE_LANES-1:0] data_sram_wen;
  logic [31:0]           data_sram_addr;
  logic [WORD_W-1:0]     data_sram_wdata;
  logic [WORD_W-1:0]     data_sram_rdata;
  logic                  d_stall;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, d_stall
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, d_stall
  );
endinterface

// File: rtl/dsram_byte_array.sv
// Byte-writable synchronous word store with a registered read port; no reset so it maps to BRAM.
module dsram_byte_array
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic [BYTE_LANES-1:0] we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [WORD_W-1:0]     rdata
);
  logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];

  // Read sees the pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/dsram_wait_responder.sv
// Data-SRAM responder that inserts LATENCY stall cycles in front of a local byte-writable array.
module dsram_wait_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dsram_wait_responder_if.slave dsram,
  output logic [31:0]           acc_cnt
);
  if (LATENCY < 0 || LATENCY > MAX_LATENCY || (2**CNT_W) <= LATENCY) begin : g_bad_cfg
    $error("dsram_wait_responder: LATENCY must be 0..15 and fit in CNT_W bits");
  end

  dsram_state_t          state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  latch, commit, fire, rd_fire, rd_ok;
  logic [BYTE_LANES-1:0] wen_q, acc_wen;
  logic [ADDR_W-1:0]     idx_q, acc_idx, idx_in;
  logic [WORD_W-1:0]     wdata_q, acc_wdata, arr_rdata;
  logic                  unused_addr_bits;

  assign idx_in           = dsram.data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{dsram.data_sram_addr[31:ADDR_W+2], dsram.data_sram_addr[1:0]};

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    latch         = 1'b0;
    commit        = 1'b0;
    dsram.d_stall = 1'b0;
    if (LATENCY == 0) begin
      commit = dsram.data_sram_en;
    end else begin
      unique case (state)
        IDLE: begin
          if (dsram.data_sram_en) begin
            dsram.d_stall = 1'b1;
            latch         = 1'b1;
            cnt_nxt       = CNT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
            state_nxt     = WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            dsram.d_stall = 1'b1;
            cnt_nxt       = cnt - 1'b1;
          end else begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // With zero latency the live request is the access; otherwise the latched copy is.
  assign acc_wen   = (LATENCY == 0) ? dsram.data_sram_wen   : wen_q;
  assign acc_idx   = (LATENCY == 0) ? idx_in                : idx_q;
  assign acc_wdata = (LATENCY == 0) ? dsram.data_sram_wdata : wdata_q;

  // A reset edge suppresses any commit so an aborted access leaves no trace.
  assign fire    = commit & ~rst;
  assign rd_fire = fire & (acc_wen == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_cnt <= '0;
      rd_ok   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (fire) begin
        acc_cnt <= acc_cnt + 32'd1;
      end
      if (rd_fire) begin
        rd_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      wen_q   <= dsram.data_sram_wen;
      idx_q   <= idx_in;
      wdata_q <= dsram.data_sram_wdata;
    end
  end

  dsram_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (fire ? acc_wen : '0),
    .waddr (acc_idx),
    .wdata (acc_wdata),
    .re    (rd_fire),
    .raddr (acc_idx),
    .rdata (arr_rdata)
  );

  // The array output has no reset, so report zero until the first read after reset.
  assign dsram.data_sram_rdata = rd_ok ? arr_rdata : '0;
endmodule

// File: tb/tb_dsram_wait_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 0, 3) driven with directed accesses.
module tb_dsram_wait_responder;
  typedef struct {
    string       nm;
    logic [31:0] acc;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        rst_v   [3];
  logic        rst_q   [3];
  logic        en_d    [3];
  logic [3:0]  wen_d   [3];
  logic [31:0] addr_d  [3];
  logic [31:0] wdata_d [3];
  logic        stall_m [3];
  logic [31:0] rd_m    [3];
  logic [31:0] acc_m   [3];
  logic [31:0] acc_a, acc_b, acc_c;
  logic [31:0] exp_acc [3];
  logic [31:0] last_rd [3];
  exp_t        sb [3][$];
  int          checks = 0;
  int          errors = 0;

  dsram_wait_responder_if bus_a ();
  dsram_wait_responder_if bus_b ();
  dsram_wait_responder_if bus_c ();

  dsram_wait_responder #(.ADDR_W(10), .LATENCY(2), .CNT_W(4)) u_l2 (
    .clk(clk), .rst(rst_v[0]), .dsram(bus_a), .acc_cnt(acc_a));
  dsram_wait_responder #(.ADDR_W(10), .LATENCY(0), .CNT_W(4)) u_l0 (
    .clk(clk), .rst(rst_v[1]), .dsram(bus_b), .acc_cnt(acc_b));
  dsram_wait_responder #(.ADDR_W(10), .LATENCY(3), .CNT_W(4)) u_l3 (
    .clk(clk), .rst(rst_v[2]), .dsram(bus_c), .acc_cnt(acc_c));

  assign bus_a.data_sram_en = en_d[0];  assign bus_a.data_sram_wen = wen_d[0];
  assign bus_a.data_sram_addr = addr_d[0];  assign bus_a.data_sram_wdata = wdata_d[0];
  assign bus_b.data_sram_en = en_d[1];  assign bus_b.data_sram_wen = wen_d[1];
  assign bus_b.data_sram_addr = addr_d[1];  assign bus_b.data_sram_wdata = wdata_d[1];
  assign bus_c.data_sram_en = en_d[2];  assign bus_c.data_sram_wen = wen_d[2];
  assign bus_c.data_sram_addr = addr_d[2];  assign bus_c.data_sram_wdata = wdata_d[2];
  assign stall_m[0] = bus_a.d_stall;  assign rd_m[0] = bus_a.data_sram_rdata;  assign acc_m[0] = acc_a;
  assign stall_m[1] = bus_b.d_stall;  assign rd_m[1] = bus_b.data_sram_rdata;  assign acc_m[1] = acc_b;
  assign stall_m[2] = bus_c.d_stall;  assign rd_m[2] = bus_c.data_sram_rdata;  assign acc_m[2] = acc_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) rst_q[k] <= rst_v[k];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, req);
    end
  endtask

  // Monitor: every change of acc_cnt marks a commit; pop and compare its expected outcome.
  initial begin
    logic [31:0] prev [3];
    exp_t e;
    for (int k = 0; k < 3; k++) prev[k] = 32'd0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_q[k] === 1'b1) begin
          prev[k] = acc_m[k];
        end else if (acc_m[k] !== prev[k]) begin
          prev[k] = acc_m[k];
          if (sb[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected commit acc=%0d required none", k, acc_m[k]);
          end else begin
            e = sb[k].pop_front();
            check({e.nm, " acc_cnt"}, acc_m[k], e.acc);
            check({e.nm, " rdata"}, rd_m[k], e.rd);
          end
        end
      end
    end
  end

  task automatic access(input int k, input string nm, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_stalls, input logic [31:0] exp_rd, input bit scramble);
    int n;
    bit done;
    exp_acc[k] = exp_acc[k] + 32'd1;
    if (wen == 4'b0000) last_rd[k] = exp_rd;
    sb[k].push_back('{nm, exp_acc[k], last_rd[k]});
    en_d[k] = 1'b1; wen_d[k] = wen; addr_d[k] = addr; wdata_d[k] = wdata;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall_m[k]) begin
        n++;
        @(posedge clk); #1;
        if (scramble) begin
          addr_d[k] = 32'h0000_0020; wen_d[k] = 4'b1111; wdata_d[k] = 32'hFFFF_FFFF;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s stall timeout actual=stuck required=release", nm);
    end
    check({nm, " stalls"}, 32'(n), 32'(exp_stalls));
    @(posedge clk); #1;
    en_d[k] = 1'b0; wen_d[k] = 4'b0000; addr_d[k] = 32'd0; wdata_d[k] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; en_d[k] = 1'b0; wen_d[k] = 4'b0000;
      addr_d[k] = 32'd0; wdata_d[k] = 32'd0; exp_acc[k] = 32'd0; last_rd[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("idle%0d d_stall", k), 32'(stall_m[k]), 32'd0);
        check($sformatf("idle%0d rdata", k), rd_m[k], 32'd0);
        check($sformatf("idle%0d acc_cnt", k), acc_m[k], 32'd0);
      end
    end
    @(posedge clk); #1;

    // LATENCY=2: full word write/read, then wrapped unaligned address
    access(0, "l2 wr10", 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'd0, 1'b0);
    access(0, "l2 rd10", 4'b0000, 32'h0000_0010, 32'd0, 2, 32'hDEAD_BEEF, 1'b0);
    access(0, "l2 wrwrap", 4'b1111, 32'h0000_1013, 32'hCAFE_F00D, 2, 32'd0, 1'b0);
    access(0, "l2 rdwrap", 4'b0000, 32'h0000_0010, 32'd0, 2, 32'hCAFE_F00D, 1'b0);

    // LATENCY=0: back-to-back byte-lane merge
    access(1, "l0 wr10", 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'd0, 1'b0);
    access(1, "l0 wrlanes", 4'b0101, 32'h0000_0010, 32'h1122_3344, 0, 32'd0, 1'b0);
    access(1, "l0 rd10", 4'b0000, 32'h0000_0010, 32'd0, 0, 32'hDE22_BE44, 1'b0);
    access(1, "l0 wrhi", 4'b1000, 32'h0000_0010, 32'h99AA_BBCC, 0, 32'd0, 1'b0);
    access(1, "l0 rd10b", 4'b0000, 32'h0000_0010, 32'd0, 0, 32'h9922_BE44, 1'b0);

    // LATENCY=3: inputs changed while stalled must be ignored
    access(2, "l3 wr20", 4'b1111, 32'h0000_0020, 32'h1234_5678, 3, 32'd0, 1'b0);
    access(2, "l3 wr10", 4'b1111, 32'h0000_0010, 32'h0BAD_F00D, 3, 32'd0, 1'b0);
    access(2, "l3 rd10scr", 4'b0000, 32'h0000_0010, 32'd0, 3, 32'h0BAD_F00D, 1'b1);
    access(2, "l3 rd20", 4'b0000, 32'h0000_0020, 32'd0, 3, 32'h1234_5678, 1'b0);
    access(2, "l3 wr30", 4'b1111, 32'h0000_0030, 32'h5555_5555, 3, 32'd0, 1'b0);

    // LATENCY=3: reset in the second stall cycle aborts the pending write
    en_d[2] = 1'b1; wen_d[2] = 4'b1111; addr_d[2] = 32'h0000_0030; wdata_d[2] = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    rst_v[2] = 1'b1;
    @(posedge clk); #1;
    rst_v[2] = 1'b0; en_d[2] = 1'b0; wen_d[2] = 4'b0000; addr_d[2] = 32'd0; wdata_d[2] = 32'd0;
    exp_acc[2] = 32'd0;
    last_rd[2] = 32'd0;
    @(negedge clk);
    check("rstwait acc_cnt", acc_m[2], 32'd0);
    check("rstwait rdata", rd_m[2], 32'd0);
    check("rstwait d_stall", 32'(stall_m[2]), 32'd0);
    @(posedge clk); #1;
    access(2, "l3 rd30", 4'b0000, 32'h0000_0030, 32'd0, 3, 32'h5555_5555, 1'b0);

    repeat (4) @(posedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("sb%0d drained", k), 32'(sb[k].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
